alu_op_sequencer: RTL and testbench
===================================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter WIDTH, 32, operand/result width.
REQ-002 Parameter SETTLE, 1, extra cycles ALU inputs are held before result capture (range 0..15).
REQ-003 Parameter DEPTH, 2, command FIFO entries (power of two, >=2).
REQ-004 Port clk  in  1  sole clock, rising edge.
REQ-005 Port rst_n  in  1  reset; the block SHALL use one clock, and rst_n SHALL be asynchronous and active-low.
REQ-006 Port cmd_valid  in  1  command offered.
REQ-007 Port cmd_ready  out  1  FIFO can accept.
REQ-008 Port cmd_a, cmd_b  in  WIDTH  operands A, B.
REQ-009 Port cmd_op  in  3  ALU opcode.
REQ-010 Port R2, R3  out  WIDTH  registered operands driven to the ALU.
REQ-011 Port opcode  out  3  registered opcode driven to the ALU.
REQ-012 Port R0  in  WIDTH  ALU result.
REQ-013 Port overflow, zero, carry  in  1  ALU flags.
REQ-014 Port rsp_valid  out  1  response present.
REQ-015 Port rsp_ready  in  1  response consumed.
REQ-016 Port rsp_data  out  WIDTH  captured R0.
REQ-017 Port rsp_flags  out  3  captured {overflow, zero, carry}.
REQ-018 Port busy  out  1  high when state != IDLE or FIFO non-empty.
REQ-019 Port chk_err  out  1  sticky zero-flag mismatch (see Configuration).

Function
REQ-020 Command accepted on a clk edge with cmd_valid && cmd_ready; {cmd_a, cmd_b, cmd_op} SHALL be pushed into the FIFO.
REQ-021 cmd_ready SHALL equal !full, from registered count; accept and pop in the same cycle SHALL both occur.
REQ-022 FSM states IDLE, ISSUE, HOLD, RESP, SHALL encode in order.
REQ-023 IDLE -> ISSUE when FIFO non-empty; otherwise remain.
REQ-024 ISSUE: on exit edge, load R2/R3/opcode from FIFO head, pop, clear settle counter, go HOLD.
REQ-025 HOLD: count SETTLE further edges; on the (SETTLE+1)th HOLD edge capture R0 and flags into rsp_data/rsp_flags, set rsp_valid, go RESP.
REQ-026 Latency: command accepted at edge E0 into empty idle block -> rsp_valid high after edge E0+3+SETTLE (E0+4 with default).
REQ-027 RESP: rsp_data/rsp_flags/rsp_valid SHALL hold stable until rsp_ready is sampled high; then clear rsp_valid and go IDLE.
REQ-028 R2/R3/opcode SHALL hold last-issued values in all states except ISSUE exit.
REQ-029 Commands SHALL complete strictly in acceptance order; none dropped or duplicated.
REQ-030 Opcodes ignoring operand B (000, 001, 010) SHALL still drive cmd_b onto R3 unchanged.
REQ-031 FIFO pointers SHALL wrap modulo DEPTH; count saturates at DEPTH, never overflows/underflows.

Reset
REQ-032 While rst_n low: state IDLE, FIFO empty, R2=R3=0, opcode=0, rsp_data=0, rsp_flags=0, rsp_valid=0, cmd_ready=0, busy=0, chk_err=0.
REQ-033 Reset asserted mid-operation SHALL discard FIFO contents and any pending response immediately.
REQ-034 cmd_ready SHALL rise on the first clk edge after rst_n deasserts.

Configuration
REQ-035 Macro ALU_SEQ_ZCHK_EN defined: at HOLD capture, if zero != (R0 == 0), chk_err SHALL set and stay set until reset; rsp_flags unaffected.
REQ-036 Macro ALU_SEQ_ZCHK_EN undefined: no compare logic built; chk_err tied 0.

Verification
REQ-037 Single op: cmd_a=5, cmd_b=3, cmd_op=100, rsp_ready=1 -> R2=5, R3=3, opcode=100 after ISSUE; rsp_valid at E0+4 with rsp_data=ALU R0 (2).
REQ-038 Back-to-back: 3 commands on consecutive cycles, DEPTH=2 -> cmd_ready low on 3rd until first pop; responses in order.
REQ-039 Backpressure: rsp_ready=0 for 10 cycles -> rsp_valid, rsp_data, rsp_flags constant; completes one edge after rsp_ready=1.
REQ-040 Reset mid-HOLD with 2 queued commands -> all outputs zero, no response ever emitted for them.
REQ-041 ALU_SEQ_ZCHK_EN defined, ALU model forces zero=1 with R0=7 -> chk_err=1 sticky; undefined -> chk_err stays 0.
REQ-042 SETTLE=0 and SETTLE=3 builds -> rsp_valid at E0+3 and E0+6 respectively.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// Bundles the command, ALU-side and response signals of alu_op_sequencer.
// Handshakes on cmd_* and rsp_* use valid/ready: a transfer happens on a
// rising clk edge where valid and ready are both high. valid, once raised,
// holds its payload stable until that edge. ready may change freely.
// state_dbg exposes the sequencer FSM state.
interface alu_op_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] R2;
    logic [WIDTH-1:0] R3;
    logic [2:0]       opcode;
    logic [WIDTH-1:0] R0;
    logic             overflow;
    logic             zero;
    logic             carry;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic [2:0]       rsp_flags;
    logic             busy;
    logic             chk_err;
    logic [1:0]       state_dbg;

    // Sequencer side.
    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, R0, overflow, zero, carry, rsp_ready,
        output cmd_ready, R2, R3, opcode, rsp_valid, rsp_data, rsp_flags, busy,
        output chk_err, state_dbg
    );

    // Environment side: command source, ALU and response sink.
    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, R0, overflow, zero, carry, rsp_ready,
        input  cmd_ready, R2, R3, opcode, rsp_valid, rsp_data, rsp_flags, busy,
        input  chk_err, state_dbg
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: queues ALU commands in a small FIFO, drives each one onto
// the registered ALU inputs (R2/R3/opcode), waits SETTLE extra cycles, then
// captures R0 and the flags as a response held until consumed.
// Optional macro ALU_SEQ_ZCHK_EN builds a sticky zero-flag consistency check.
module alu_op_sequencer #(
    parameter int WIDTH  = 32,
    parameter int SETTLE = 1,
    parameter int DEPTH  = 2
) (
    input  logic clk,
    input  logic rst_n,
    alu_op_sequencer_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int EW = 2 * WIDTH + 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state;
    logic [EW-1:0]    mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             ready_en;
    logic [3:0]       settle_cnt;
    logic             push;
    logic             pop;
    logic             capture;
    logic [WIDTH-1:0] head_a;
    logic [WIDTH-1:0] head_b;
    logic [2:0]       head_op;

    assign push    = bus.cmd_valid && bus.cmd_ready;
    assign pop     = (state == ISSUE) && (count != '0);
    assign capture = (state == HOLD) && (settle_cnt == 4'(SETTLE));
    assign {head_a, head_b, head_op} = mem[rd_ptr];

    // ready_en keeps cmd_ready low during reset and for the first edge after it.
    assign bus.cmd_ready = ready_en && (count != CW'(DEPTH));
    assign bus.busy      = (state != IDLE) || (count != '0);
    assign bus.state_dbg = state;

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.cmd_a, bus.cmd_b, bus.cmd_op};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally as DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sequencer FSM with registered ALU inputs and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            settle_cnt    <= '0;
            bus.R2        <= '0;
            bus.R3        <= '0;
            bus.opcode    <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_flags <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (count != '0) state <= ISSUE;
                end
                ISSUE: begin
                    bus.R2     <= head_a;
                    bus.R3     <= head_b;
                    bus.opcode <= head_op;
                    settle_cnt <= '0;
                    state      <= HOLD;
                end
                HOLD: begin
                    if (capture) begin
                        bus.rsp_data  <= bus.R0;
                        bus.rsp_flags <= {bus.overflow, bus.zero, bus.carry};
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_SEQ_ZCHK_EN
    // Sticky flag: ALU zero output disagrees with the result it reported.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.chk_err <= 1'b0;
        end else if (capture && (bus.zero != (bus.R0 == '0))) begin
            bus.chk_err <= 1'b1;
        end
    end
`else
    assign bus.chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed latency, back-to-back,
// backpressure, zero-check and reset-mid-operation steps, then random traffic
// scored against a queue of responses computed from the commands.
module tb_alu_op_sequencer;
    localparam int W      = 32;
    localparam int SETTLE = 1;
    localparam int DEPTH  = 2;
    localparam int EW     = 3 * W + 6;
`ifdef ALU_SEQ_ZCHK_EN
    localparam logic ZCHK = 1'b1;
`else
    localparam logic ZCHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic force_zero = 1'b0;
    logic rand_rdy = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [EW-1:0] exp_q[$];
    logic [W+2:0]  alu_out;

    alu_op_sequencer_if #(.WIDTH(W)) bus ();

    alu_op_sequencer #(.WIDTH(W), .SETTLE(SETTLE), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- ALU model: returns {overflow, zero, carry, result} ----------------
    function automatic logic [W+2:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [2:0] op, input logic fz);
        logic [W:0]   t;
        logic [W-1:0] r;
        logic         c;
        logic         ov;
        t = '0; c = 1'b0; ov = 1'b0;
        case (op)
            3'd0: r = a;
            3'd1: r = ~a;
            3'd2: begin
                t = {1'b0, a} + (W+1)'(1);
                r = t[W-1:0]; c = t[W];
                ov = !a[W-1] && r[W-1];
            end
            3'd3: begin
                t = {1'b0, a} + {1'b0, b};
                r = t[W-1:0]; c = t[W];
                ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'd4: begin
                t = {1'b0, a} - {1'b0, b};
                r = t[W-1:0]; c = t[W];
                ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'd5: r = a & b;
            3'd6: r = a | b;
            default: r = a ^ b;
        endcase
        return {ov, fz | (r == '0), c, r};
    endfunction

    always_comb alu_out = alu_fn(bus.R2, bus.R3, bus.opcode, force_zero);
    assign bus.R0 = alu_out[W-1:0];
    assign {bus.overflow, bus.zero, bus.carry} = alu_out[W+2:W];

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string where);
        check({where, "_R2"}, bus.R2, 0);
        check({where, "_R3"}, bus.R3, 0);
        check({where, "_opcode"}, bus.opcode, 0);
        check({where, "_rsp_valid"}, bus.rsp_valid, 0);
        check({where, "_rsp_data"}, bus.rsp_data, 0);
        check({where, "_rsp_flags"}, bus.rsp_flags, 0);
        check({where, "_cmd_ready"}, bus.cmd_ready, 0);
        check({where, "_busy"}, bus.busy, 0);
        check({where, "_chk_err"}, bus.chk_err, 0);
        check({where, "_state"}, bus.state_dbg, 0);
    endtask

    // Expected response layout: {a, b, op, data, flags}.
    task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
        logic [W+2:0] x;
        x = alu_fn(a, b, op, force_zero);
        exp_q.push_back({a, b, op, x[W-1:0], x[W+2:W]});
    endtask

    // ---------------- scoreboard: response handshakes in acceptance order ----------------
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", bus.rsp_valid, 0);
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                check("rsp_data", bus.rsp_data, e[W+2:3]);
                check("rsp_flags", bus.rsp_flags, e[2:0]);
                check("R2_held", bus.R2, e[3*W+5:2*W+6]);
                check("R3_held", bus.R3, e[2*W+5:W+6]);
                check("opcode_held", bus.opcode, e[W+5:W+3]);
            end
        end
    end

    // ---------------- drivers ----------------
    // Random rsp_ready, changed just after each rising edge while enabled.
    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            bus.rsp_ready = 1'($urandom_range(0, 1));
        end
    end

    // Offer one command starting just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
        int n;
        n = 0;
        bus.cmd_a = a; bus.cmd_b = b; bus.cmd_op = op; bus.cmd_valid = 1'b1;
        @(negedge clk);
        while (!bus.cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("cmd_accept", bus.cmd_ready, 1);
        if (bus.cmd_ready) push_exp(a, b, op);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    // Drain: rsp_ready forced high, wait for the block to empty (bounded).
    task automatic wait_idle();
        int n;
        n = 0;
        rand_rdy = 1'b0;
        @(posedge clk); #2;
        bus.rsp_ready = 1'b1;
        while ((bus.busy || bus.rsp_valid || exp_q.size() != 0) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_busy", bus.busy, 0);
        check("idle_queue_empty", exp_q.size(), 0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [EW-1:0] e;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        int            n;

        bus.cmd_valid = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_op = '0;
        bus.rsp_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", bus.cmd_ready, 1);
        check("busy_after_reset", bus.busy, 0);

        // Single op 5 - 3 with exact latency
        bus.rsp_ready = 1'b1;
        bus.cmd_a = 5; bus.cmd_b = 3; bus.cmd_op = 3'b100; bus.cmd_valid = 1'b1;
        @(negedge clk);
        check("single_ready", bus.cmd_ready, 1);
        push_exp(5, 3, 3'b100);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        for (int k = 1; k <= 3 + SETTLE; k++) begin
            @(posedge clk); #1;
            check("latency_rsp_valid", bus.rsp_valid, (k == 3 + SETTLE));
            if (k == 2) begin
                check("issue_R2", bus.R2, 5);
                check("issue_R3", bus.R3, 3);
                check("issue_opcode", bus.opcode, 3'b100);
            end
        end
        check("single_rsp_data", bus.rsp_data, 2);
        wait_idle();

        // Back-to-back: third command stalls until the first pop
        send(32'h10, 32'h20, 3'b011);
        send(32'hFFFF_FFFF, 32'h1, 3'b011);
        check("full_ready_low", bus.cmd_ready, 0);
        send(32'h1234, 32'h9999, 3'b000);
        wait_idle();

        // Backpressure for 10 cycles
        bus.rsp_ready = 1'b0;
        send($urandom, $urandom, 3'b110);
        n = 0;
        while (!bus.rsp_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_rsp_valid_wait", bus.rsp_valid, 1);
        e = exp_q[0];
        for (int k = 0; k < 10; k++) begin
            check("bp_valid_hold", bus.rsp_valid, 1);
            check("bp_data_hold", bus.rsp_data, e[W+2:3]);
            check("bp_flags_hold", bus.rsp_flags, e[2:0]);
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_complete", bus.rsp_valid, 0);
        check("bp_consumed", exp_q.size(), 0);
        wait_idle();

        // Zero-flag consistency check: zero forced high while R0 = 7
        force_zero = 1'b1;
        send(7, 0, 3'b000);
        wait_idle();
        force_zero = 1'b0;
        check("chk_err_set", bus.chk_err, ZCHK);
        send(5, 5, 3'b100);
        wait_idle();
        check("chk_err_sticky", bus.chk_err, ZCHK);

        // Random traffic with random response backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 4) == 0) a = '1;
            send(a, b, 3'($urandom_range(0, 7)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        wait_idle();
        check("chk_err_after_random", bus.chk_err, ZCHK);

        // Reset mid-HOLD with two commands queued
        send(32'hA, 32'h1, 32'h3);
        send(32'hB, 32'h2, 3'b011);
        send(32'hC, 32'h3, 3'b011);
        check("pre_reset_state_hold", bus.state_dbg, 2);
        check("pre_reset_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        exp_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("post_reset_rsp_valid", bus.rsp_valid, 0);
        check("post_reset_busy", bus.busy, 0);
        check("post_reset_ready", bus.cmd_ready, 1);
        check("post_reset_chk_err", bus.chk_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
